// File: rtl/leaf_ingress_queue_if.sv
// Handshake bundle between the GPU, the ingress queue and the leaf router's GPU input port.
// The master side drives GPU offers and router consumption; the slave side is the queue.
interface leaf_ingress_queue_if #(
  parameter int DWIDTH     = 16,
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [DWIDTH-1:0] gpu_in_data;
  logic              gpu_in_valid;
  logic [5:0]        gpu_dest_addr;
  logic              gpu_in_ready;
  logic [DWIDTH-1:0] rtr_data;
  logic              rtr_valid;
  logic [5:0]        rtr_dest_addr;
  logic              rtr_is_local;
  logic              rtr_ready;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [7:0]        drop_count;

  modport master (
    output gpu_in_data, gpu_in_valid, gpu_dest_addr, rtr_ready,
    input  gpu_in_ready, rtr_data, rtr_valid, rtr_dest_addr, rtr_is_local,
           fifo_full, fifo_empty, fifo_count, drop_count
  );

  modport slave (
    input  gpu_in_data, gpu_in_valid, gpu_dest_addr, rtr_ready,
    output gpu_in_ready, rtr_data, rtr_valid, rtr_dest_addr, rtr_is_local,
           fifo_full, fifo_empty, fifo_count, drop_count
  );
endinterface

// File: rtl/leaf_ingress_queue.sv
// GPU ingress FIFO for a group-1 leaf router: show-ahead head, registered status,
// saturating drop counter and a same-group flag for the head packet.
module leaf_ingress_queue #(
  parameter int         DWIDTH     = 16,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [3:0] GROUP_ID   = 4'b0001
) (
  input logic                clk,
  input logic                reset,
  leaf_ingress_queue_if.slave q_if
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DWIDTH + 6;

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    drop_q, drop_d;
  logic          full_s, empty_s, push_s, pop_s, drop_s;
  logic [EW-1:0] head_s;

  // Status is decoded from the occupancy register only, so no input reaches an output.
  assign full_s  = (count_q == CW'(FIFO_DEPTH));
  assign empty_s = (count_q == {CW{1'b0}});
  assign push_s  = q_if.gpu_in_valid && !full_s;
  assign pop_s   = q_if.rtr_ready && !empty_s;
  assign drop_s  = q_if.gpu_in_valid && full_s;
  assign head_s  = mem_q[rd_ptr_q];

  assign q_if.gpu_in_ready  = !full_s;
  assign q_if.fifo_full     = full_s;
  assign q_if.fifo_empty    = empty_s;
  assign q_if.fifo_count    = count_q;
  assign q_if.drop_count    = drop_q;
  assign q_if.rtr_valid     = !empty_s;
  assign q_if.rtr_data      = head_s[DWIDTH-1:0];
  assign q_if.rtr_dest_addr = head_s[EW-1:DWIDTH];
  assign q_if.rtr_is_local  = !empty_s && (head_s[EW-1:EW-4] == GROUP_ID);

  // Storage write; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {q_if.gpu_dest_addr, q_if.gpu_in_data};
    end
  end

  // Next-state for pointers, occupancy and the saturating drop counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (drop_s && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end else begin
      drop_d = drop_q;
    end
  end

  // State registers; reset wins over any push or pop in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      drop_q   <= 8'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end
endmodule
